// File: rtl/mem_arb_pkg.sv
// Shared types for the IF/DM memory-port arbiter: FSM states, owner encoding,
// latched downstream request layout and grant vector bit positions.
package mem_arb_pkg;

  localparam int ARB_AW  = 32;
  localparam int ARB_DW  = 32;
  localparam int ARB_BEW = ARB_DW / 8;
  localparam int CNT_W   = 4;

  localparam int GNT_IF = 0;
  localparam int GNT_DM = 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } owner_e;

  typedef struct packed {
    logic [ARB_AW-1:0]  addr;
    logic               we;
    logic [ARB_DW-1:0]  wdata;
    logic [ARB_BEW-1:0] be;
  } mem_req_t;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner select: data wins ties unless fetch has been passed over
// STARVE_MAX times in a row. Output is one-hot (or zero when nobody requests).
module mem_arb_pick
  import mem_arb_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic             if_valid,
  input  logic             dm_valid,
  input  logic [CNT_W-1:0] starve_cnt,
  output logic [1:0]       grant
);

  logic if_starved;

  assign if_starved = (starve_cnt == CNT_W'(STARVE_MAX));

  always_comb begin
    grant = '0;
    if (if_valid && (!dm_valid || if_starved)) begin
      grant[GNT_IF] = 1'b1;
    end else if (dm_valid) begin
      grant[GNT_DM] = 1'b1;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch and load/store, one transaction in flight.
// Accept at N, mem request from N+1, response passed through in the cycle it arrives.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW         = ARB_AW,
  parameter int DW         = ARB_DW,
  parameter int STARVE_MAX = 4
) (
  input  logic            clk,
  input  logic            rst,

  input  logic            if_req_valid,
  output logic            if_req_ready,
  input  logic [AW-1:0]   if_req_addr,
  output logic            if_rsp_valid,
  output logic [DW-1:0]   if_rsp_rdata,

  input  logic            dm_req_valid,
  output logic            dm_req_ready,
  input  logic [AW-1:0]   dm_req_addr,
  input  logic            dm_req_we,
  input  logic [DW-1:0]   dm_req_wdata,
  input  logic [DW/8-1:0] dm_req_be,
  output logic            dm_rsp_valid,
  output logic [DW-1:0]   dm_rsp_rdata,

  output logic            mem_req_valid,
  input  logic            mem_req_ready,
  output logic [AW-1:0]   mem_req_addr,
  output logic            mem_req_we,
  output logic [DW-1:0]   mem_req_wdata,
  output logic [DW/8-1:0] mem_req_be,
  input  logic            mem_rsp_valid,
  input  logic [DW-1:0]   mem_rsp_rdata,

  output logic            busy,
  output logic            owner,
  output logic            err_spurious
);

  arb_state_e       state;
  owner_e           own_q;
  mem_req_t         req_q;
  logic [CNT_W-1:0] starve_cnt;
  logic [CNT_W-1:0] starve_inc;
  logic [1:0]       grant;
  logic             rsp_fire;

  mem_arb_pick #(.STARVE_MAX(STARVE_MAX)) u_pick (
    .if_valid   (if_req_valid),
    .dm_valid   (dm_req_valid),
    .starve_cnt (starve_cnt),
    .grant      (grant)
  );

  assign if_req_ready = (state == IDLE) && grant[GNT_IF];
  assign dm_req_ready = (state == IDLE) && grant[GNT_DM];

  assign starve_inc = (starve_cnt >= CNT_W'(STARVE_MAX)) ? starve_cnt
                                                          : starve_cnt + CNT_W'(1);

  // Responses are forwarded combinationally so the owner sees them in the arrival cycle.
  assign rsp_fire     = (state == WAIT) && mem_rsp_valid;
  assign if_rsp_valid = rsp_fire && (own_q == OWN_IF);
  assign dm_rsp_valid = rsp_fire && (own_q == OWN_DM);
  assign if_rsp_rdata = if_rsp_valid ? mem_rsp_rdata : '0;
  assign dm_rsp_rdata = dm_rsp_valid ? mem_rsp_rdata : '0;

  assign mem_req_valid = (state == ISSUE);
  assign mem_req_addr  = req_q.addr;
  assign mem_req_we    = req_q.we;
  assign mem_req_wdata = req_q.wdata;
  assign mem_req_be    = req_q.be;

  assign busy  = (state != IDLE);
  assign owner = own_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      own_q        <= OWN_IF;
      req_q        <= '0;
      starve_cnt   <= '0;
      err_spurious <= 1'b0;
    end else begin
      if (mem_rsp_valid && (state != WAIT)) begin
        err_spurious <= 1'b1;
      end
      unique case (state)
        IDLE: begin
          if (grant[GNT_DM]) begin
            req_q      <= '{addr: dm_req_addr, we: dm_req_we, wdata: dm_req_wdata, be: dm_req_be};
            own_q      <= OWN_DM;
            starve_cnt <= if_req_valid ? starve_inc : '0;
            state      <= ISSUE;
          end else if (grant[GNT_IF]) begin
            // Fetch is always a full-word read.
            req_q      <= '{addr: if_req_addr, we: 1'b0, wdata: '0, be: '1};
            own_q      <= OWN_IF;
            starve_cnt <= '0;
            state      <= ISSUE;
          end
        end
        ISSUE: begin
          if (mem_req_ready) begin
            state <= WAIT;
          end
        end
        WAIT: begin
          if (mem_rsp_valid) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
